// File: rtl/car_pkg.sv
// car_pkg: shared definitions for the car_top stimulus sequencer.
//   - FSM state encoding for car_stim_seq
//   - UART frame geometry (8N1: 1 start + 8 data + 1 stop)
//   - default bit period for a 100 MHz clock at 115200 baud
//   - cnt_width(): width of a counter that must reach n-1 (never less than 1)
package car_pkg;

  localparam int UART_BITS       = 10;
  localparam int DATA_W          = 8;
  localparam int CLK_DIV_DEFAULT = 868;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_GO_P  = 3'd5;
  localparam logic [2:0] ST_EX_P  = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

  typedef logic [2:0] car_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/car_uart_tx.sv
// car_uart_tx: 8N1 serializer.
//   clk        system clock
//   srst       synchronous active-high reset; line returns to idle (1)
//   load       one-cycle request; captures data and starts a frame on this edge
//   data       byte to send, LSB first
//   txd        serial output, idles high
//   bit_last   high in the final cycle of the current bit period
//   bit_pos    current bit: 0 = start, 1..8 = data bits 0..7, 9 = stop
//   frame_done high in the final cycle of the stop bit
// A load in the same cycle as frame_done starts the next frame back to back.
module car_uart_tx
  import car_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              txd,
  output logic              bit_last,
  output logic [3:0]        bit_pos,
  output logic              frame_done
);

  localparam int               CNT_W         = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLK_DIV - 1);
  localparam logic [3:0]       POS_LAST      = 4'(UART_BITS - 1);
  localparam logic [3:0]       POS_LAST_DATA = 4'(DATA_W);

  logic              active_reg;
  logic              txd_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [3:0]        bit_pos_reg;
  logic [CNT_W-1:0]  cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      active_reg  <= 1'b0;
      txd_reg     <= 1'b1;
      shift_reg   <= '0;
      bit_pos_reg <= '0;
      cnt_reg     <= '0;
    end else if (load) begin
      active_reg  <= 1'b1;
      txd_reg     <= 1'b0;
      shift_reg   <= data;
      bit_pos_reg <= '0;
      cnt_reg     <= '0;
    end else if (active_reg) begin
      if (cnt_reg == CNT_LAST) begin
        cnt_reg <= '0;
        if (bit_pos_reg == POS_LAST) begin
          active_reg <= 1'b0;
          txd_reg    <= 1'b1;
        end else begin
          bit_pos_reg <= bit_pos_reg + 4'd1;
          // After the last data bit the line goes to the stop level.
          txd_reg     <= (bit_pos_reg == POS_LAST_DATA) ? 1'b1 : shift_reg[0];
          shift_reg   <= {1'b0, shift_reg[DATA_W-1:1]};
        end
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign txd        = txd_reg;
  assign bit_pos    = bit_pos_reg;
  assign bit_last   = active_reg && (cnt_reg == CNT_LAST);
  assign frame_done = bit_last && (bit_pos_reg == POS_LAST);

endmodule

// File: rtl/car_stim_seq.sv
// car_stim_seq: plays a loadable table of command bytes into car_top.rxd as
// 8N1 UART frames, then pulses go followed by excute.
//   clk        system clock
//   I_rst      synchronous active-high reset (clears the FSM, not the table)
//   start      one-cycle run request, accepted only while idle
//   n_cmds     bytes to send (clamped to DEPTH), sampled at accepted start
//   cmd_we     table write strobe, ignored while busy
//   cmd_waddr  table write address
//   cmd_wdata  table write data
//   rxd        serial line to car_top, idles high
//   go         go pulse, PULSE_CYC cycles
//   excute     excute pulse, PULSE_CYC cycles, follows go
//   busy       high from the cycle after accepted start through done
//   done       one-cycle completion pulse
//   byte_idx   bytes fully sent in the current run; holds after done
module car_stim_seq
  import car_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEFAULT,
  parameter int DEPTH     = 16,
  parameter int GAP_CYC   = 16,
  parameter int PULSE_CYC = 4
) (
  input  logic                   clk,
  input  logic                   I_rst,
  input  logic                   start,
  input  logic [$clog2(DEPTH):0] n_cmds,
  input  logic                   cmd_we,
  input  logic [$clog2(DEPTH)-1:0] cmd_waddr,
  input  logic [7:0]             cmd_wdata,
  output logic                   rxd,
  output logic                   go,
  output logic                   excute,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] byte_idx
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int IDX_W   = ADDR_W + 1;
  localparam int GAP_W   = cnt_width(GAP_CYC);
  localparam int PULSE_W = cnt_width(PULSE_CYC);

  localparam logic [IDX_W-1:0]   DEPTH_IDX     = IDX_W'(DEPTH);
  localparam logic [GAP_W-1:0]   GAP_LAST      = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [PULSE_W-1:0] PULSE_LAST    = PULSE_W'(PULSE_CYC - 1);
  localparam logic [3:0]         POS_LAST_DATA = 4'(DATA_W);
  localparam bit                 HAS_GAP       = (GAP_CYC > 0);

  car_state_t state_reg, state_next;

  logic [IDX_W-1:0]   byte_idx_reg;
  logic [IDX_W-1:0]   n_lat_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic [PULSE_W-1:0] pulse_cnt_reg;
  logic [7:0]         cmd_mem [DEPTH];

  logic               idle;
  logic               start_acc;
  logic               wr_en;
  logic [IDX_W-1:0]   n_clamped;
  logic [IDX_W-1:0]   idx_plus1;
  logic               uart_load;
  logic [ADDR_W-1:0]  load_addr;
  logic [7:0]         load_data;
  logic               uart_txd;
  logic               bit_last;
  logic [3:0]         bit_pos;
  logic               frame_done;

  assign idle      = (state_reg == ST_IDLE);
  assign start_acc = start && idle;
  assign wr_en     = cmd_we && idle;
  assign n_clamped = (n_cmds > DEPTH_IDX) ? DEPTH_IDX : n_cmds;
  assign idx_plus1 = byte_idx_reg + IDX_W'(1);

  // Command table. Small enough to read combinationally straight into the
  // serializer's shift register, which acts as the read register.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      cmd_mem[cmd_waddr] <= cmd_wdata;
    end
  end

  // A write in the same cycle as an accepted start must be the byte that goes
  // out, so bypass the array when addresses match.
  assign load_data = (wr_en && (cmd_waddr == load_addr)) ? cmd_wdata : cmd_mem[load_addr];

  car_uart_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_uart_tx (
    .clk        (clk),
    .srst       (I_rst),
    .load       (uart_load),
    .data       (load_data),
    .txd        (uart_txd),
    .bit_last   (bit_last),
    .bit_pos    (bit_pos),
    .frame_done (frame_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (I_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; also decides when and what the serializer loads.
  always_comb begin
    state_next = state_reg;
    uart_load  = 1'b0;
    load_addr  = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (n_clamped == '0) begin
            state_next = ST_GO_P;
          end else begin
            state_next = ST_START;
            uart_load  = 1'b1;
          end
        end
      end
      ST_START: begin
        if (bit_last) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (bit_last && (bit_pos == POS_LAST_DATA)) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (frame_done) begin
          if (HAS_GAP) begin
            state_next = ST_GAP;
          end else if (idx_plus1 < n_lat_reg) begin
            // No gap: the next frame starts right after this stop bit.
            state_next = ST_START;
            uart_load  = 1'b1;
            load_addr  = idx_plus1[ADDR_W-1:0];
          end else begin
            state_next = ST_GO_P;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          if (byte_idx_reg < n_lat_reg) begin
            state_next = ST_START;
            uart_load  = 1'b1;
            load_addr  = byte_idx_reg[ADDR_W-1:0];
          end else begin
            state_next = ST_GO_P;
          end
        end
      end
      ST_GO_P: begin
        if (pulse_cnt_reg == PULSE_LAST) state_next = ST_EX_P;
      end
      ST_EX_P: begin
        if (pulse_cnt_reg == PULSE_LAST) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Run bookkeeping and the gap / pulse counters. Counters restart whenever
  // the state changes so each GAP, GO_P and EX_P visit begins from zero.
  always_ff @(posedge clk) begin
    if (I_rst) begin
      byte_idx_reg  <= '0;
      n_lat_reg     <= '0;
      gap_cnt_reg   <= '0;
      pulse_cnt_reg <= '0;
    end else begin
      if (start_acc) begin
        byte_idx_reg <= '0;
        n_lat_reg    <= n_clamped;
      end else if ((state_reg == ST_STOP) && frame_done) begin
        byte_idx_reg <= idx_plus1;
      end

      if ((state_reg == ST_GAP) && (state_next == ST_GAP)) begin
        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
      end else begin
        gap_cnt_reg <= '0;
      end

      if (((state_reg == ST_GO_P) || (state_reg == ST_EX_P)) && (state_next == state_reg)) begin
        pulse_cnt_reg <= pulse_cnt_reg + PULSE_W'(1);
      end else begin
        pulse_cnt_reg <= '0;
      end
    end
  end

  // Outputs.
  always_comb begin
    rxd      = uart_txd;
    go       = (state_reg == ST_GO_P);
    excute   = (state_reg == ST_EX_P);
    busy     = !idle;
    done     = (state_reg == ST_DONE);
    byte_idx = byte_idx_reg;
  end

endmodule

// File: tb/tb_car_stim_seq.sv
// Scoreboard bench for car_stim_seq (CLK_DIV=4, DEPTH=4, GAP_CYC=2, PULSE_CYC=3).
// The driver pushes expected bytes and expected run timing when it issues a
// start; a UART monitor decodes rxd and a control monitor watches go/excute/done.
module tb_car_stim_seq;

  localparam int CLK_DIV   = 4;
  localparam int DEPTH     = 4;
  localparam int GAP_CYC   = 2;
  localparam int PULSE_CYC = 3;
  localparam int FRAME     = 10 * CLK_DIV + GAP_CYC;  // 42 cycles per byte

  logic       clk = 1'b0;
  logic       I_rst;
  logic       start;
  logic [2:0] n_cmds;
  logic       cmd_we;
  logic [1:0] cmd_waddr;
  logic [7:0] cmd_wdata;
  logic       rxd, go, excute, busy, done;
  logic [2:0] byte_idx;

  car_stim_seq #(
    .CLK_DIV   (CLK_DIV),
    .DEPTH     (DEPTH),
    .GAP_CYC   (GAP_CYC),
    .PULSE_CYC (PULSE_CYC)
  ) dut (
    .clk       (clk),
    .I_rst     (I_rst),
    .start     (start),
    .n_cmds    (n_cmds),
    .cmd_we    (cmd_we),
    .cmd_waddr (cmd_waddr),
    .cmd_wdata (cmd_wdata),
    .rxd       (rxd),
    .go        (go),
    .excute    (excute),
    .busy      (busy),
    .done      (done),
    .byte_idx  (byte_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int go_off;
    int done_off;
    int nbytes;
  } run_t;

  run_t       run_q[$];
  logic [7:0] byte_q[$];
  int         checks = 0;
  int         errors = 0;
  int         start_cyc = 0;
  int         epoch = 0;
  bit         mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART monitor: samples the second cycle of every bit period.
  initial begin : uart_mon
    logic [7:0] b;
    logic       st;
    logic       stop_bit;
    logic [7:0] exp_b;
    int         ep;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (rxd === 1'b0) begin
        ep = epoch;
        @(negedge clk);
        st = rxd;
        for (int k = 0; k < 8; k++) begin
          repeat (CLK_DIV) @(negedge clk);
          b[k] = rxd;
        end
        repeat (CLK_DIV) @(negedge clk);
        stop_bit = rxd;
        if (ep == epoch) begin
          if (byte_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got byte 0x%02h, none expected", b);
          end else begin
            exp_b = byte_q.pop_front();
            chk("frame_byte", int'(b), int'(exp_b));
            chk("start_bit", int'(st), 0);
            chk("stop_bit", int'(stop_bit), 1);
            $display("frame: byte 0x%02h (expected 0x%02h) at cycle %0d", b, exp_b, cyc);
          end
        end
      end
    end
  end

  // Control monitor: go/excute timing and width, done timing and byte_idx.
  initial begin : ctl_mon
    int   go_len;
    int   ex_len;
    logic go_d;
    logic ex_d;
    run_t r;
    go_len = 0;
    ex_len = 0;
    go_d   = 1'b0;
    ex_d   = 1'b0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (go || excute) chk("go_excute_exclusive", int'(go && excute), 0);
      if (go && !go_d) begin
        if (run_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_go: go rose at cycle %0d with no run pending", cyc);
        end else begin
          chk("go_offset", cyc - start_cyc, run_q[0].go_off);
        end
      end
      if (excute && !ex_d && run_q.size() != 0)
        chk("excute_offset", cyc - start_cyc, run_q[0].go_off + PULSE_CYC);
      if (go) go_len++;
      else if (go_d) begin
        chk("go_width", go_len, PULSE_CYC);
        go_len = 0;
      end
      if (excute) ex_len++;
      else if (ex_d) begin
        chk("excute_width", ex_len, PULSE_CYC);
        ex_len = 0;
      end
      if (done) begin
        if (run_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done at cycle %0d with no run pending", cyc);
        end else begin
          r = run_q.pop_front();
          chk("done_offset", cyc - start_cyc, r.done_off);
          chk("done_byte_idx", int'(byte_idx), r.nbytes);
          chk("busy_at_done", int'(busy), 1);
          $display("run: done after %0d cycles (expected %0d), byte_idx=%0d (expected %0d)",
                   cyc - start_cyc, r.done_off, byte_idx, r.nbytes);
        end
      end
      go_d = go;
      ex_d = excute;
    end
  end

  task automatic write_cmd(input logic [1:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    cmd_we    = 1'b1;
    cmd_waddr = addr;
    cmd_wdata = data;
    @(posedge clk); #1;
    cmd_we    = 1'b0;
  endtask

  // Issue an accepted start and push the expected response.
  task automatic start_run(input int n, input int n_eff,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic we, input logic [1:0] wa, input logic [7:0] wd);
    run_t       r;
    logic [7:0] bs[4];
    bs = '{b0, b1, b2, b3};
    @(posedge clk); #1;
    start     = 1'b1;
    n_cmds    = 3'(n);
    cmd_we    = we;
    cmd_waddr = wa;
    cmd_wdata = wd;
    start_cyc = cyc;
    for (int i = 0; i < n_eff; i++) byte_q.push_back(bs[i]);
    r.go_off   = 1 + n_eff * FRAME;
    r.done_off = r.go_off + 2 * PULSE_CYC;
    r.nbytes   = n_eff;
    run_q.push_back(r);
    @(negedge clk);
    chk("idle_before_start", int'(busy), 0);
    @(posedge clk); #1;
    start  = 1'b0;
    cmd_we = 1'b0;
    @(negedge clk);
    chk("busy_after_start", int'(busy), 1);
    chk("first_cycle_rxd", int'(rxd), (n_eff == 0) ? 1 : 0);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (run_q.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy=%0d with %0d runs pending after %0d cycles",
               busy, run_q.size(), budget);
      run_q.delete();
      byte_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    I_rst     = 1'b1;
    start     = 1'b0;
    n_cmds    = '0;
    cmd_we    = 1'b0;
    cmd_waddr = '0;
    cmd_wdata = '0;
    repeat (3) @(posedge clk);
    #1 I_rst = 1'b0;
    @(negedge clk);
    chk("reset_rxd", int'(rxd), 1);
    chk("reset_go", int'(go), 0);
    chk("reset_excute", int'(excute), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_byte_idx", int'(byte_idx), 0);
    mon_en = 1'b1;

    write_cmd(2'd0, 8'hA5);
    write_cmd(2'd1, 8'h3C);

    // 1: two bytes, done at 1 + 2*42 + 6 = 91
    start_run(2, 2, 8'hA5, 8'h3C, 8'h00, 8'h00, 1'b0, 2'd0, 8'h00);
    wait_idle(200);

    // 2: no bytes, go at 1..3, excute at 4..6, done at 7
    start_run(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 8'h00);
    wait_idle(50);

    // 3: a second start during DATA of the first byte is ignored
    start_run(2, 2, 8'hA5, 8'h3C, 8'h00, 8'h00, 1'b0, 2'd0, 8'h00);
    repeat (10) @(posedge clk);
    #1;
    start  = 1'b1;
    n_cmds = 3'd1;
    @(posedge clk); #1;
    start  = 1'b0;
    wait_idle(200);
    repeat (20) @(negedge clk);
    chk("byte_idx_hold", int'(byte_idx), 2);

    // 4: reset during the second byte's DATA, then replay from byte 0
    start_run(2, 2, 8'hA5, 8'h3C, 8'h00, 8'h00, 1'b0, 2'd0, 8'h00);
    repeat (55) @(posedge clk);
    #1;
    I_rst = 1'b1;
    byte_q.delete();
    run_q.delete();
    epoch++;
    @(posedge clk); #1;
    I_rst = 1'b0;
    @(negedge clk);
    chk("midrst_rxd", int'(rxd), 1);
    chk("midrst_go", int'(go), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_byte_idx", int'(byte_idx), 0);
    repeat (50) @(posedge clk);
    start_run(2, 2, 8'hA5, 8'h3C, 8'h00, 8'h00, 1'b0, 2'd0, 8'h00);
    wait_idle(200);

    // 5a: a write while busy is dropped, so 0x3C is still sent
    start_run(2, 2, 8'hA5, 8'h3C, 8'h00, 8'h00, 1'b0, 2'd0, 8'h00);
    repeat (8) @(posedge clk);
    #1;
    cmd_we    = 1'b1;
    cmd_waddr = 2'd1;
    cmd_wdata = 8'h77;
    @(posedge clk); #1;
    cmd_we    = 1'b0;
    wait_idle(200);

    // 5b: write and start in the same cycle, the new byte goes out
    start_run(2, 2, 8'h5A, 8'h3C, 8'h00, 8'h00, 1'b1, 2'd0, 8'h5A);
    wait_idle(200);

    // 6: n_cmds=7 clamps to DEPTH=4, done at 1 + 4*42 + 6 = 175
    write_cmd(2'd2, 8'h81);
    write_cmd(2'd3, 8'h0F);
    start_run(7, 4, 8'h5A, 8'h3C, 8'h81, 8'h0F, 1'b0, 2'd0, 8'h00);
    wait_idle(400);

    repeat (10) @(negedge clk);
    chk("byte_q_drained", byte_q.size(), 0);
    chk("run_q_drained", run_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
